qkd_shift_rx: RTL



---
 rtl/qkd_shift_rx.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/qkd_shift_rx.sv
// Serial frame receiver: rebuilds LSB-first framed words from a shift-register
// transmitter, buffers them in a FIFO and exposes data/status over Avalon-MM.
module qkd_shift_rx #(
  parameter int WORD_W     = 32,
  parameter int BIT_PERIOD = 50,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        serial_in,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        irq
);

  localparam int CW = $clog2(BIT_PERIOD);
  localparam int IW = $clog2(WORD_W + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n;
  logic [WORD_W-1:0]   shreg, shreg_n;
  logic                sync1, sync2, s_d, s, fall, expire;
  logic                push_req, frame_err;

  logic                en, irq_en;
  logic                err_ovf, err_frame, err_unf;
  logic [31:0]         word_count;
  logic [31:0]         mem [FIFO_DEPTH];
  logic [LW-1:0]       wr_ptr, rd_ptr, level;
  logic                empty, full, pop, push_ok, ovf_set, unf_set, flush, wc_clr;
  logic [2:0]          w1c;
  logic [31:0]         word_ext, status, rd_mux;
  logic [1:0]          st_code;
  logic                unused_wdata;

  assign unused_wdata = &{1'b0, avs_writedata[31:5]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      s_d   <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      s_d   <= sync2;
    end
  end

  assign s      = sync2;
  assign fall   = s_d & ~s;
  assign expire = (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shreg_n   = shreg;
    push_req  = 1'b0;
    frame_err = 1'b0;
    if (!en) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:
          if (fall) begin
            cnt_n   = CW'(BIT_PERIOD / 2 - 1);
            state_n = S_START;
          end
        S_START:
          if (!expire) cnt_n = cnt - 1'b1;
          else if (!s) begin
            cnt_n   = CW'(BIT_PERIOD - 1);
            idx_n   = '0;
            state_n = S_DATA;
          end else state_n = S_IDLE;
        S_DATA:
          if (!expire) cnt_n = cnt - 1'b1;
          else begin
            shreg_n = {s, shreg[WORD_W-1:1]};
            cnt_n   = CW'(BIT_PERIOD - 1);
            if (idx == IW'(WORD_W - 1)) state_n = S_STOP;
            else idx_n = idx + 1'b1;
          end
        S_STOP:
          if (!expire) cnt_n = cnt - 1'b1;
          else if (s) begin
            push_req = 1'b1;
            state_n  = S_IDLE;
          end else begin
            frame_err = 1'b1;
            state_n   = S_BREAK;
          end
        S_BREAK:
          if (s) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    word_ext = '0;
    word_ext[WORD_W-1:0] = shreg;
  end

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign pop     = avs_read && (avs_address == 2'd0) && !empty;
  assign unf_set = avs_read && (avs_address == 2'd0) && empty;
  // A same-cycle pop makes room, so a push into a full FIFO still lands.
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;
  assign flush   = avs_write && (avs_address == 2'd2) && avs_writedata[2];
  assign wc_clr  = avs_write && (avs_address == 2'd3);
  assign w1c     = (avs_write && (avs_address == 2'd1)) ? avs_writedata[4:2] : 3'b000;

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= word_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en         <= 1'b0;
      irq_en     <= 1'b0;
      err_ovf    <= 1'b0;
      err_frame  <= 1'b0;
      err_unf    <= 1'b0;
      word_count <= '0;
    end else begin
      if (avs_write && (avs_address == 2'd2)) begin
        en     <= avs_writedata[0];
        irq_en <= avs_writedata[1];
      end
      err_ovf   <= (err_ovf   & ~w1c[0]) | ovf_set;
      err_frame <= (err_frame & ~w1c[1]) | frame_err;
      err_unf   <= (err_unf   & ~w1c[2]) | unf_set;
      if (wc_clr)        word_count <= push_req ? 32'd1 : '0;
      else if (push_req) word_count <= word_count + 32'd1;
    end
  end

  always_comb begin
    case (state)
      S_START, S_DATA: st_code = 2'd1;
      S_STOP:          st_code = 2'd2;
      S_BREAK:         st_code = 2'd3;
      default:         st_code = 2'd0;
    endcase
    status         = '0;
    status[0]      = empty;
    status[1]      = full;
    status[2]      = err_ovf;
    status[3]      = err_frame;
    status[4]      = err_unf;
    status[8 +: LW] = level;
    status[17:16]  = st_code;
    case (avs_address)
      2'd0:    rd_mux = empty ? '0 : mem[rd_ptr[AW-1:0]];
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {30'd0, irq_en, en};
      default: rd_mux = word_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

  assign irq = irq_en && !empty;

endmodule
